// File: rtl/vedic_mul_rr_sched.sv
// -----------------------------------------------------------------------------
// vedic_mul_rr_sched
//   Round-robin scheduler that shares one external pipelined W x W multiplier
//   among NREQ requesters. At most one operand pair is granted per cycle and
//   registered onto the multiplier inputs. A tag pipe of matching depth tracks
//   each in-flight product so that it returns with the id of its issuer.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active high
//   en         in   1 = new grants allowed; in-flight products always drain
//   req_valid  in   [NREQ]     per-requester operand pair valid
//   req_ready  out  [NREQ]     one-hot grant (combinational from req_valid)
//   req_a      in   [NREQ*W]   operand A, requester i at [i*W +: W]
//   req_b      in   [NREQ*W]   operand B, same packing
//   mul_a      out  [W]        registered operand A to the multiplier
//   mul_b      out  [W]        registered operand B to the multiplier
//   mul_s      in   [2*W]      multiplier product, MUL_LAT cycles after mul_a/b
//   res_valid  out  result strobe, one cycle per product, no backpressure
//   res_id     out  [IDW]      requester that owns res_data
//   res_data   out  [2*W]      registered product
//   inflight   out  [IDW+3]    issued products not yet returned
//   busy       out  inflight != 0
// -----------------------------------------------------------------------------
module vedic_mul_rr_sched #(
   parameter int unsigned W       = 64,
   parameter int unsigned NREQ    = 4,
   parameter int unsigned IDW     = 2,
   parameter int unsigned MUL_LAT = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*W-1:0]   req_a,
   input  logic [NREQ*W-1:0]   req_b,
   output logic [W-1:0]        mul_a,
   output logic [W-1:0]        mul_b,
   input  logic [2*W-1:0]      mul_s,
   output logic                res_valid,
   output logic [IDW-1:0]      res_id,
   output logic [2*W-1:0]      res_data,
   output logic [IDW+2:0]      inflight,
   output logic                busy
);

   localparam logic [IDW+2:0] CNT_ONE = (IDW+3)'(1);

   logic [IDW-1:0]   ptr_q, ptr_d;
   logic             grant_v;
   logic [IDW-1:0]   grant_id;

   logic [W-1:0]     mul_a_q, mul_a_d;
   logic [W-1:0]     mul_b_q, mul_b_d;
   logic             iss_v_q;
   logic [IDW-1:0]   iss_id_q;

   logic             tag_v_q  [MUL_LAT];
   logic [IDW-1:0]   tag_id_q [MUL_LAT];

   logic             res_valid_q;
   logic [IDW-1:0]   res_id_q;
   logic [2*W-1:0]   res_data_q;
   logic [IDW+2:0]   inflight_q, inflight_d;

   // Round-robin search split into two passes: indices above ptr first, then
   // wrap to indices at or below ptr. This is the modulo-NREQ walk starting at
   // ptr+1 without needing a variable-width index computation.
   always_comb begin
      req_ready = '0;
      grant_v   = 1'b0;
      grant_id  = '0;
      if (en) begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (!grant_v && req_valid[i] && (IDW'(i) > ptr_q)) begin
               grant_v      = 1'b1;
               grant_id     = IDW'(i);
               req_ready[i] = 1'b1;
            end
         end
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (!grant_v && req_valid[i] && (IDW'(i) <= ptr_q)) begin
               grant_v      = 1'b1;
               grant_id     = IDW'(i);
               req_ready[i] = 1'b1;
            end
         end
      end
   end

   // Issue stage next state: operands hold their last value when idle.
   always_comb begin
      ptr_d   = ptr_q;
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
      if (grant_v) begin
         ptr_d = grant_id;
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (req_ready[i]) begin
            mul_a_d = req_a[i*W +: W];
            mul_b_d = req_b[i*W +: W];
         end
      end
   end

   always_comb begin
      inflight_d = inflight_q;
      unique case ({grant_v, res_valid_q})
         2'b10:   inflight_d = inflight_q + CNT_ONE;
         2'b01:   inflight_d = inflight_q - CNT_ONE;
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q       <= IDW'(NREQ - 1);
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         iss_v_q     <= 1'b0;
         iss_id_q    <= '0;
         for (int unsigned i = 0; i < MUL_LAT; i++) begin
            tag_v_q[i]  <= 1'b0;
            tag_id_q[i] <= '0;
         end
         res_valid_q <= 1'b0;
         res_id_q    <= '0;
         res_data_q  <= '0;
         inflight_q  <= '0;
      end else begin
         ptr_q       <= ptr_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         iss_v_q     <= grant_v;
         iss_id_q    <= grant_id;
         tag_v_q[0]  <= iss_v_q;
         tag_id_q[0] <= iss_id_q;
         for (int unsigned i = 1; i < MUL_LAT; i++) begin
            tag_v_q[i]  <= tag_v_q[i-1];
            tag_id_q[i] <= tag_id_q[i-1];
         end
         // Tail of the tag pipe lines up with mul_s for the same issue.
         res_valid_q <= tag_v_q[MUL_LAT-1];
         if (tag_v_q[MUL_LAT-1]) begin
            res_id_q   <= tag_id_q[MUL_LAT-1];
            res_data_q <= mul_s;
         end
         inflight_q  <= inflight_d;
      end
   end

   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign res_valid = res_valid_q;
   assign res_id    = res_id_q;
   assign res_data  = res_data_q;
   assign inflight  = inflight_q;
   assign busy      = (inflight_q != '0);

endmodule

// File: tb/tb_vedic_mul_rr_sched.sv
module tb_vedic_mul_rr_sched;

   localparam int W       = 64;
   localparam int NREQ    = 4;
   localparam int IDW     = 2;
   localparam int MUL_LAT = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic                en;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*W-1:0]   req_a;
   logic [NREQ*W-1:0]   req_b;
   logic [W-1:0]        mul_a;
   logic [W-1:0]        mul_b;
   logic [2*W-1:0]      mul_s;
   logic                res_valid;
   logic [IDW-1:0]      res_id;
   logic [2*W-1:0]      res_data;
   logic [IDW+2:0]      inflight;
   logic                busy;

   always #5 clk = ~clk;

   vedic_mul_rr_sched #(
      .W       (W),
      .NREQ    (NREQ),
      .IDW     (IDW),
      .MUL_LAT (MUL_LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_s     (mul_s),
      .res_valid (res_valid),
      .res_id    (res_id),
      .res_data  (res_data),
      .inflight  (inflight),
      .busy      (busy)
   );

   // External shared multiplier: MUL_LAT-cycle pipelined unsigned product.
   logic [2*W-1:0] mpipe [MUL_LAT];
   always @(posedge clk) begin
      mpipe[0] <= {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
      for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
   end
   assign mul_s = mpipe[MUL_LAT-1];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic bit_at(input logic [NREQ-1:0] v, input int i);
      logic [NREQ-1:0] s;
      s = v >> i;
      return s[0];
   endfunction

   function automatic logic [W-1:0] op_at(input logic [NREQ*W-1:0] v, input int i);
      logic [NREQ*W-1:0] s;
      s = v >> (i*W);
      return s[W-1:0];
   endfunction

   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [NREQ*W-1:0] m;
      m     = {{(NREQ-1)*W{1'b0}}, {W{1'b1}}} << (i*W);
      req_a = (req_a & ~m) | ({{(NREQ-1)*W{1'b0}}, a} << (i*W));
      req_b = (req_b & ~m) | ({{(NREQ-1)*W{1'b0}}, b} << (i*W));
   endtask

   // Monitor: reference arbiter, scoreboard and event logs.
   int             cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int             mon_ptr;
   int             idx;
   int             n_xfer = 0;
   int             peak   = 0;
   logic [NREQ-1:0] exp_rdy;
   int             exp_id_q   [$];
   logic [2*W-1:0] exp_data_q [$];
   int             grant_log  [$];
   int             grant_cyc  [$];
   int             strobe_ids [$];
   int             strobe_cyc [$];
   logic [2*W-1:0] strobe_dat [$];

   always @(negedge clk) begin
      if (rst) begin
         mon_ptr = NREQ - 1;
         exp_id_q.delete();
         exp_data_q.delete();
      end else begin
         exp_rdy = '0;
         if (en) begin
            for (int k = 1; k <= NREQ; k++) begin
               idx = (mon_ptr + k) % NREQ;
               if (exp_rdy == '0 && bit_at(req_valid, idx)) exp_rdy = NREQ'(1) << idx;
            end
         end
         check("arb_ready", 128'(req_ready), 128'(exp_rdy));
         for (int i = 0; i < NREQ; i++) begin
            if (bit_at(exp_rdy, i)) begin
               mon_ptr = i;
               n_xfer++;
               exp_id_q.push_back(i);
               exp_data_q.push_back({{W{1'b0}}, op_at(req_a, i)} * {{W{1'b0}}, op_at(req_b, i)});
            end
            if (bit_at(req_valid & req_ready, i)) begin
               grant_log.push_back(i);
               grant_cyc.push_back(cyc);
            end
         end
         if (int'(inflight) > peak) peak = int'(inflight);
         if (res_valid) begin
            strobe_ids.push_back(int'(res_id));
            strobe_cyc.push_back(cyc);
            strobe_dat.push_back(res_data);
            if (exp_id_q.size() == 0) begin
               check("unexpected_strobe", 1, 0);
            end else begin
               check("sb_id", 128'(res_id), 128'(exp_id_q.pop_front()));
               check("sb_data", res_data, exp_data_q.pop_front());
            end
         end
      end
   end

   task automatic clear_logs();
      grant_log.delete();
      grant_cyc.delete();
      strobe_ids.delete();
      strobe_cyc.delete();
      strobe_dat.delete();
      peak   = 0;
      n_xfer = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      req_valid = '0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         if (!busy) done = 1'b1;
      end
      if (!done) check("drain_timeout", 1, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NREQ-1:0] ready_or;
      logic            seen;
      logic            busy_at_last;
      logic            busy_after;
      int              last_strobe;

      rst = 1'b1; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_res_valid", 128'(res_valid), 0);
      check("rst_inflight",  128'(inflight), 0);
      check("rst_busy",      128'(busy), 0);
      check("rst_ready",     128'(req_ready), 0);
      check("rst_mul_a",     128'(mul_a), 0);
      check("rst_res_data",  res_data, 0);
      @(posedge clk); #1;
      rst = 1'b0; en = 1'b1;

      // 1: single request, max operands, exact latency
      clear_logs();
      @(posedge clk); #1;
      set_op(0, '1, '1);
      req_valid = 4'b0001;
      @(negedge clk);
      check("t1_grant", 128'(req_ready), 128'(4'b0001));
      @(posedge clk); #1;
      req_valid = '0;
      for (int i = 0; i < MUL_LAT + 1; i++) begin
         @(negedge clk);
         check("t1_quiet", 128'(res_valid), 0);
      end
      @(negedge clk);
      check("t1_strobe", 128'(res_valid), 1);
      check("t1_id",     128'(res_id), 0);
      check("t1_data",   res_data, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
      check("t1_busy_at_strobe", 128'(busy), 1);
      @(negedge clk);
      check("t1_busy_after", 128'(busy), 0);
      check("t1_inflight",   128'(inflight), 0);
      check("t1_single",     128'(res_valid), 0);
      check("t1_data_hold",  res_data, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

      // 2: all four requesters for 8 cycles
      do_reset();
      clear_logs();
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) set_op(i, W'(i + 1), W'(100 + i));
      req_valid = '1;
      repeat (8) @(posedge clk);
      #1 req_valid = '0;
      wait_idle();
      check("t2_ngrant",  128'(grant_log.size()), 8);
      check("t2_nstrobe", 128'(strobe_ids.size()), 8);
      for (int k = 0; k < 8 && k < grant_log.size() && k < strobe_ids.size(); k++) begin
         check("t2_grant_id",  128'(grant_log[k]), 128'(k % 4));
         check("t2_strobe_id", 128'(strobe_ids[k]), 128'(k % 4));
         check("t2_b2b",       128'(strobe_cyc[k] - strobe_cyc[0]), 128'(k));
      end
      if (strobe_cyc.size() > 0 && grant_cyc.size() > 0)
         check("t2_latency", 128'(strobe_cyc[0] - grant_cyc[0]), 128'(MUL_LAT + 2));
      check("t2_peak", 128'(peak), 128'(MUL_LAT + 2));

      // 3: only req2/req3, 3*5
      clear_logs();
      @(posedge clk); #1;
      set_op(2, 64'd3, 64'd5);
      set_op(3, 64'd3, 64'd5);
      req_valid = 4'b1100;
      repeat (4) @(posedge clk);
      #1 req_valid = '0;
      wait_idle();
      check("t3_ngrant",  128'(grant_log.size()), 4);
      check("t3_nstrobe", 128'(strobe_dat.size()), 4);
      for (int k = 0; k < 4 && k < grant_log.size() && k < strobe_dat.size(); k++) begin
         check("t3_grant_id", 128'(grant_log[k]), 128'((k % 2) + 2));
         check("t3_data",     strobe_dat[k], 128'd15);
      end

      // 4: en drops after 3 grants
      do_reset();
      clear_logs();
      @(posedge clk); #1;
      req_valid = '1;
      repeat (3) @(posedge clk);
      #1 en = 1'b0;
      ready_or = '0; last_strobe = -100; busy_at_last = 1'b0; busy_after = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         ready_or |= req_ready;
         if (cyc == last_strobe + 1) busy_after = busy;
         if (res_valid) begin
            last_strobe  = cyc;
            busy_at_last = busy;
         end
      end
      req_valid = '0; en = 1'b1;
      check("t4_no_ready",  128'(ready_or), 0);
      check("t4_ngrant",    128'(grant_log.size()), 3);
      check("t4_nstrobe",   128'(strobe_ids.size()), 3);
      check("t4_busy_last", 128'(busy_at_last), 1);
      check("t4_busy_fall", 128'(busy_after), 0);

      // 5: reset with 4 products in flight
      do_reset();
      clear_logs();
      @(posedge clk); #1;
      req_valid = '1;
      repeat (4) @(posedge clk);
      #1;
      check("t5_inflight_pre", 128'(inflight), 4);
      req_valid = '0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         seen |= res_valid;
      end
      check("t5_no_strobe", 128'(seen), 0);
      check("t5_inflight",  128'(inflight), 0);
      check("t5_busy",      128'(busy), 0);
      @(posedge clk); #1;
      req_valid = '1;
      @(negedge clk);
      check("t5_next_grant", 128'(req_ready), 128'(4'b0001));
      @(posedge clk); #1;
      req_valid = '0;
      wait_idle();

      // 6: 1000 random transfers against the scoreboard
      clear_logs();
      for (int c = 0; c < 5000 && n_xfer < 1000; c++) begin
         @(posedge clk); #1;
         if (n_xfer >= 1000) break;
         req_valid = NREQ'($urandom_range(0, 15));
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 7) == 0) set_op(i, '1, {$urandom, $urandom});
            else                           set_op(i, {$urandom, $urandom}, {$urandom, $urandom});
         end
      end
      req_valid = '0;
      wait_idle();
      check("t6_xfers",    128'(n_xfer >= 1000), 1);
      check("t6_nstrobe",  128'(strobe_ids.size()), 128'(n_xfer));
      check("t6_sb_empty", 128'(exp_id_q.size()), 0);
      check("t6_peak_max", 128'(peak <= MUL_LAT + 2), 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
